// File: rtl/trap_arbiter.sv
// Machine-mode trap front end: arbitrates exceptions and synchronised interrupts,
// issues one trap at a time and sequences handler entry, ISR run and mret return.
//   state     | meaning
//   S_IDLE    | arbitrate; capture winning cause/pc
//   S_ISSUE   | one-cycle trap request to handler, pipeline stalled
//   S_PREP    | wait for handling_flag, bounded by WAIT_MAX cycles
//   S_HANDLE  | ISR runs, pipeline free, waiting for mret
//   S_RESTORE | mret held to handler until handling_flag drops
module trap_arbiter #(
    parameter int SYNC_STAGES = 2,
    parameter int WAIT_MAX    = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_exc_valid,
    input  logic [3:0]  i_exc_code,
    input  logic [31:0] i_exc_pc,
    input  logic [31:0] i_cur_pc,
    input  logic        i_irq_ext,
    input  logic        i_irq_sw,
    input  logic        i_irq_timer,
    input  logic        i_gie,
    input  logic [2:0]  i_ie_mask,
    input  logic        i_mret_in,
    input  logic        i_handling_flag,
    output logic        o_trap_req,
    output logic [31:0] o_trap_cause,
    output logic [31:0] o_trap_pc,
    output logic        o_mret_out,
    output logic        o_pipe_stall,
    output logic        o_trap_taken,
    output logic [2:0]  o_irq_pending,
    output logic        o_err_timeout,
    output logic        o_err_nested
);

    localparam int CW = $clog2(WAIT_MAX + 1);
    localparam int SW = 3 * SYNC_STAGES;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_PREP,
        S_HANDLE,
        S_RESTORE
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [SW-1:0]   r_sync;
    logic [2:0]      w_irq_sync;
    logic [2:0]      w_irq_pend;
    logic [31:0]     w_cause_nxt;
    logic [31:0]     w_pc_nxt;
    logic            w_timeout_set;
    logic            w_nested;

    // Each 3-bit slice is one synchroniser stage for {ext,sw,timer}.
    assign w_irq_sync = r_sync[SW-1 -: 3];
    assign w_irq_pend = w_irq_sync & i_ie_mask;

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_cause_nxt   = o_trap_cause;
        w_pc_nxt      = o_trap_pc;
        w_timeout_set = 1'b0;
        w_nested      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_exc_valid) begin
                    w_cause_nxt = {28'b0, i_exc_code};
                    w_pc_nxt    = i_exc_pc;
                    w_state_nxt = S_ISSUE;
                end else if (i_gie && (|w_irq_pend)) begin
                    w_pc_nxt    = i_cur_pc;
                    w_state_nxt = S_ISSUE;
                    if (w_irq_pend[2])      w_cause_nxt = 32'h8000_000B;
                    else if (w_irq_pend[1]) w_cause_nxt = 32'h8000_0003;
                    else                    w_cause_nxt = 32'h8000_0007;
                end
            end
            S_ISSUE: begin
                // Down-counter terminal count at zero gives WAIT_MAX PREP cycles.
                w_cnt_nxt   = CW'(WAIT_MAX - 1);
                w_state_nxt = S_PREP;
            end
            S_PREP: begin
                w_nested = i_exc_valid;
                if (i_handling_flag) begin
                    w_state_nxt = S_HANDLE;
                end else if (r_cnt == '0) begin
                    w_timeout_set = 1'b1;
                    w_state_nxt   = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            S_HANDLE: begin
                w_nested = i_exc_valid;
                if (i_mret_in) w_state_nxt = S_RESTORE;
            end
            S_RESTORE: begin
                w_nested = i_exc_valid;
                if (!i_handling_flag) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_sync        <= '0;
            o_trap_req    <= 1'b0;
            o_trap_cause  <= '0;
            o_trap_pc     <= '0;
            o_mret_out    <= 1'b0;
            o_pipe_stall  <= 1'b0;
            o_trap_taken  <= 1'b0;
            o_irq_pending <= '0;
            o_err_timeout <= 1'b0;
            o_err_nested  <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_sync        <= {r_sync[SW-4:0], i_irq_ext, i_irq_sw, i_irq_timer};
            o_trap_req    <= (w_state_nxt == S_ISSUE);
            o_trap_cause  <= w_cause_nxt;
            o_trap_pc     <= w_pc_nxt;
            o_mret_out    <= (w_state_nxt == S_RESTORE);
            o_pipe_stall  <= (w_state_nxt == S_ISSUE) || (w_state_nxt == S_PREP)
                             || (w_state_nxt == S_RESTORE);
            o_trap_taken  <= (r_state == S_PREP) && (w_state_nxt == S_HANDLE);
            o_irq_pending <= w_irq_pend;
            o_err_timeout <= o_err_timeout | w_timeout_set;
            o_err_nested  <= o_err_nested | w_nested;
        end
    end

endmodule

// File: tb/tb_trap_arbiter.sv
// Scoreboarded bench for trap_arbiter: expected {cause,pc} queued at stimulus time,
// popped when trap_req is observed.
module tb_trap_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_exc_valid = 1'b0;
    logic [3:0]  i_exc_code = '0;
    logic [31:0] i_exc_pc = '0;
    logic [31:0] i_cur_pc = '0;
    logic        i_irq_ext = 1'b0;
    logic        i_irq_sw = 1'b0;
    logic        i_irq_timer = 1'b0;
    logic        i_gie = 1'b0;
    logic [2:0]  i_ie_mask = '0;
    logic        i_mret_in = 1'b0;
    logic        i_handling_flag = 1'b0;
    logic        o_trap_req;
    logic [31:0] o_trap_cause;
    logic [31:0] o_trap_pc;
    logic        o_mret_out;
    logic        o_pipe_stall;
    logic        o_trap_taken;
    logic [2:0]  o_irq_pending;
    logic        o_err_timeout;
    logic        o_err_nested;

    int          n_assert = 0;
    int          n_fail = 0;
    logic [63:0] exp_q[$];
    logic [63:0] mon_e;

    trap_arbiter #(.SYNC_STAGES(2), .WAIT_MAX(15)) dut (
        .clk(clk), .rst(rst),
        .i_exc_valid(i_exc_valid), .i_exc_code(i_exc_code), .i_exc_pc(i_exc_pc),
        .i_cur_pc(i_cur_pc), .i_irq_ext(i_irq_ext), .i_irq_sw(i_irq_sw),
        .i_irq_timer(i_irq_timer), .i_gie(i_gie), .i_ie_mask(i_ie_mask),
        .i_mret_in(i_mret_in), .i_handling_flag(i_handling_flag),
        .o_trap_req(o_trap_req), .o_trap_cause(o_trap_cause), .o_trap_pc(o_trap_pc),
        .o_mret_out(o_mret_out), .o_pipe_stall(o_pipe_stall), .o_trap_taken(o_trap_taken),
        .o_irq_pending(o_irq_pending), .o_err_timeout(o_err_timeout),
        .o_err_nested(o_err_nested)
    );

    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_assert++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    always @(negedge clk) begin
        if (rst && o_trap_req === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk_val("unexpected_trap", 64'd1, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk_val("trap_cause", {32'b0, o_trap_cause}, {32'b0, mon_e[63:32]});
                chk_val("trap_pc", {32'b0, o_trap_pc}, {32'b0, mon_e[31:0]});
            end
        end
    end

    // Drive a synchronous exception at the current negedge and queue its expectation.
    task automatic drive_exc(input logic [3:0] code, input logic [31:0] pc);
        i_exc_valid = 1'b1;
        i_exc_code  = code;
        i_exc_pc    = pc;
        exp_q.push_back({28'b0, code, pc});
    endtask

    // Called at the negedge where trap_req is seen (ISSUE); runs the handler handshake.
    task automatic service(input bit nest);
        @(negedge clk);
        chk_val("prep_stall", 64'(o_pipe_stall), 64'd1);
        chk_val("req_pulse", 64'(o_trap_req), 64'd0);
        i_handling_flag = 1'b1;
        i_mret_in       = 1'b1;
        @(negedge clk);
        i_mret_in = 1'b0;
        chk_val("taken_pulse", 64'(o_trap_taken), 64'd1);
        chk_val("handle_stall", 64'(o_pipe_stall), 64'd0);
        chk_val("mret_in_prep_ignored", 64'(o_mret_out), 64'd0);
        if (nest) i_exc_valid = 1'b1;
        @(negedge clk);
        i_exc_valid = 1'b0;
        chk_val("taken_once", 64'(o_trap_taken), 64'd0);
        if (nest) chk_val("err_nested", 64'(o_err_nested), 64'd1);
        i_mret_in = 1'b1;
        @(negedge clk);
        i_mret_in = 1'b0;
        chk_val("mret_out_set", 64'(o_mret_out), 64'd1);
        chk_val("restore_stall", 64'(o_pipe_stall), 64'd1);
        @(negedge clk);
        chk_val("mret_out_held", 64'(o_mret_out), 64'd1);
        i_handling_flag = 1'b0;
        @(negedge clk);
        chk_val("mret_out_clr", 64'(o_mret_out), 64'd0);
        chk_val("idle_stall", 64'(o_pipe_stall), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        #1;
        chk_val("rst_outputs", {o_trap_req, o_mret_out, o_pipe_stall, o_trap_taken,
                o_irq_pending, o_err_timeout, o_err_nested}, 64'd0);
        chk_val("rst_cause_pc", {o_trap_cause, o_trap_pc}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // 1: plain exception, one-cycle latency
        drive_exc(4'd2, 32'h100);
        @(negedge clk);
        chk_val("t1_latency", 64'(o_trap_req), 64'd1);
        i_exc_valid = 1'b0;
        service(1'b0);

        // 2: timer interrupt, SYNC_STAGES extra cycles
        i_gie = 1'b1; i_ie_mask = 3'b001; i_irq_timer = 1'b1; i_cur_pc = 32'h200;
        exp_q.push_back({32'h8000_0007, 32'h200});
        @(negedge clk);
        chk_val("t2_no_req_c1", 64'(o_trap_req), 64'd0);
        @(negedge clk);
        chk_val("t2_no_req_c2", 64'(o_trap_req), 64'd0);
        @(negedge clk);
        chk_val("t2_req_c3", 64'(o_trap_req), 64'd1);
        chk_val("t2_pending", 64'(o_irq_pending), 64'd1);
        i_irq_timer = 1'b0;
        service(1'b0);

        // 3: exception wins over simultaneous ext irq; irq follows after one IDLE cycle
        i_ie_mask = 3'b100; i_irq_ext = 1'b1; i_cur_pc = 32'h400;
        drive_exc(4'd3, 32'h300);
        exp_q.push_back({32'h8000_000B, 32'h400});
        @(negedge clk);
        chk_val("t3_exc_first", 64'(o_trap_req), 64'd1);
        i_exc_valid = 1'b0;
        service(1'b0);
        @(negedge clk);
        chk_val("t3_b2b_irq", 64'(o_trap_req), 64'd1);
        i_irq_ext = 1'b0;
        service(1'b0);

        // 4: nested exception flagged; irq with gie=0 not taken; mret in IDLE ignored
        i_gie = 1'b0; i_ie_mask = 3'b010; i_irq_sw = 1'b1;
        drive_exc(4'd0, 32'h500);
        @(negedge clk);
        chk_val("t4_req", 64'(o_trap_req), 64'd1);
        i_exc_valid = 1'b0;
        service(1'b1);
        repeat (6) @(negedge clk);
        chk_val("t4_gie0_no_req", 64'(o_trap_req), 64'd0);
        chk_val("t4_pending_sw", 64'(o_irq_pending), 64'd2);
        chk_val("t4_idle_stall", 64'(o_pipe_stall), 64'd0);
        i_mret_in = 1'b1;
        @(negedge clk);
        i_mret_in = 1'b0;
        @(negedge clk);
        chk_val("t4_mret_idle_ignored", 64'(o_mret_out), 64'd0);
        i_irq_sw = 1'b0;
        repeat (3) @(negedge clk);

        // 5: PREP timeout after WAIT_MAX cycles
        chk_val("t5_err_timeout_pre", 64'(o_err_timeout), 64'd0);
        drive_exc(4'd11, 32'h600);
        @(negedge clk);
        chk_val("t5_req", 64'(o_trap_req), 64'd1);
        i_exc_valid = 1'b0;
        c = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            c++;
            if (o_err_timeout) break;
        end
        chk_val("t5_timeout_cycles", 64'(c), 64'd16);
        chk_val("t5_stall_idle", 64'(o_pipe_stall), 64'd0);
        chk_val("t5_no_taken", 64'(o_trap_taken), 64'd0);
        @(negedge clk);
        chk_val("t5_no_reissue", 64'(o_trap_req), 64'd0);

        // 6: async reset in PREP clears everything; next exception handled normally
        drive_exc(4'd2, 32'h700);
        @(negedge clk);
        chk_val("t6_req", 64'(o_trap_req), 64'd1);
        i_exc_valid = 1'b0;
        @(negedge clk);
        chk_val("t6_prep_stall", 64'(o_pipe_stall), 64'd1);
        rst = 1'b0;
        #1;
        chk_val("t6_rst_flags", {o_trap_req, o_mret_out, o_pipe_stall, o_trap_taken,
                o_irq_pending, o_err_timeout, o_err_nested}, 64'd0);
        chk_val("t6_rst_cause_pc", {o_trap_cause, o_trap_pc}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        drive_exc(4'd3, 32'h800);
        @(negedge clk);
        chk_val("t6_after_rst_req", 64'(o_trap_req), 64'd1);
        i_exc_valid = 1'b0;
        service(1'b0);

        @(negedge clk);
        chk_val("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
